sr_write_arbiter: RTL and testbench
===================================

# sr_write_arbiter

Round-robin arbiter and sequencer that shares one shift-register serializer (the din/start/load_sr write path) between up to four requesters. It accepts whole configuration words from each requester, loads the selected word onto the serializer data bus, and issues a one-cycle start. It then waits for the serializer's load pulse and returns a per-requester acknowledge, or an error on timeout. It sits between the register-file/command side and the serializer instance.

## Interface
- N_REQ, 2: number of requesters, legal range 1..4.
- DATA_WIDTH, 170: shift-register word width; must equal the serializer's DATA_WIDTH.
- TMO_WIDTH, 9: timeout counter width; 2^TMO_WIDTH-1 must exceed DATA_WIDTH+4.

- clk  in  1  clock (clock clk).
- rst  in  1  reset (reset rst, asynchronous, active-high).
- req  in  N_REQ  level request per requester.
- req_data  in  N_REQ*DATA_WIDTH  word for requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  N_REQ  one-cycle pulse: the granted write completed.
- err  out  N_REQ  one-cycle pulse: the granted write timed out.
- busy  out  1  high from grant until the DONE cycle, inclusive.
- grant_id  out  2  index of the current or last granted requester.
- sr_din  out  DATA_WIDTH  word to the serializer; registered and stable from grant to DONE.
- sr_start  out  1  one-cycle start pulse to the serializer.
- sr_load  in  1  serializer load_sr pulse, marking completion.

## Operation
- FSM states are IDLE, GRANT, START, WAIT and DONE. All outputs are registered.
- **IDLE**
  - If any req bit is high, select a winner with round-robin from pointer (last_grant+1) mod N_REQ. The first set bit at or after the pointer wins, with wraparound.
  - On that edge: sr_din <= winner's slice of req_data, grant_id <= winner, busy <= 1. Next state is GRANT.
- **GRANT**: unconditionally go to START. sr_start <= 1.
- **START**: sr_start <= 0; clear the timeout counter. Next state is WAIT.
- **WAIT**
  - sr_load high → DONE with the success flag set.
  - Otherwise the counter increments. When the counter reaches all-ones → DONE with the fail flag set.
- **DONE**
  - ack[grant_id] pulses if the write succeeded; err[grant_id] pulses if it timed out.
  - last_grant <= grant_id; busy <= 0. Next state is IDLE.
- Requester rules:
  - A requester holds req and its data stable until it is granted.
  - req_data is captured at grant, so the requester may change data afterwards.
  - The requester must deassert req in the cycle after ack or err. Otherwise it re-competes, but at lowest priority.
  - Dropping req before grant withdraws the request without side effects.
- sr_load seen in IDLE, GRANT or START is ignored. sr_load asserted in the same edge as timeout expiry counts as success.
- With N_REQ=1, the arbiter degenerates to a sequencer. Upper grant_id bits are 0.

## Timing
- Reset values:
  - state IDLE, last_grant N_REQ-1 (so req[0] has first priority).
  - sr_din 0, sr_start 0, ack 0, err 0, busy 0, grant_id 0, counter 0.
- The edge that samples req in IDLE is e0.
  - busy, grant_id and sr_din are valid after e0.
  - sr_start is high for exactly the cycle between e1 and e2.
- If sr_load is sampled high at edge eN, ack is high for exactly the cycle between eN and eN+1. busy falls at eN+1.
- Back-to-back requests produce at least 3 idle cycles between sr_load and the next sr_start. This is enough for the serializer to return to its idle state.
- Timeout: err pulses 2^TMO_WIDTH-1 cycles after WAIT entry if sr_load never arrives. Default is 511 cycles.
- rst asserted mid-operation: immediate return to the reset values. No ack or err is issued, and the aborted requester must re-request.

## Configuration
- SR_WRITE_ARB_TIMEOUT_EN defined:
  - The timeout counter and err path are present, as described above.
- Not defined:
  - The counter is removed and WAIT exits only on sr_load.
  - err is tied to 0.
  - TMO_WIDTH is unused.

## Test plan
- **Single write:** req=01, req_data[0]=170'h3_FFFF_...A5, with a serializer model that returns sr_load 173 cycles after start.
  - Required: sr_din matches the word; exactly one sr_start pulse 2 cycles after req; ack=01 for exactly one cycle, one cycle after sr_load.
- **Simultaneous requests:** req=11 held, each requester dropping req after its ack.
  - Required: grants go req0 then req1. A second round grants req0 then req1 again. Each grant_id matches its ack bit.
- **Fairness:** req[0] held continuously while req[1] arrives during req[0]'s WAIT.
  - Required: req[1] is granted next; it is never starved.
- **Timeout (macro on):** sr_load never asserted.
  - Required: err[grant] pulses 511 cycles after WAIT entry, ack stays 0, busy falls, and the next request is served normally.
- **Reset mid-WAIT:** assert rst 50 cycles into WAIT.
  - Required: all outputs go to 0 asynchronously; a request after reset is granted to req[0] first.
- **Macro off, and spurious load:** macro undefined, sr_load withheld for 2000 cycles, then asserted.
  - Required: still in WAIT until sr_load; then ack pulses. A spurious sr_load in IDLE causes no ack.

Source files
------------

// File: rtl/sr_write_arbiter_if.sv
// Write-path bundle between requesters, the arbiter and the shared shift-register serializer.
// The slave modport is the arbiter's view; master is the requester/serializer side.
interface sr_write_arbiter_if #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 170
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            ack;
  logic [N_REQ-1:0]            err;
  logic                        busy;
  logic [1:0]                  grant_id;
  logic [DATA_WIDTH-1:0]       sr_din;
  logic                        sr_start;
  logic                        sr_load;

  modport slave (
    input  req, req_data, sr_load,
    output ack, err, busy, grant_id, sr_din, sr_start
  );

  modport master (
    output req, req_data, sr_load,
    input  ack, err, busy, grant_id, sr_din, sr_start
  );
endinterface

// File: rtl/sr_write_arbiter.sv
// Round-robin arbiter/sequencer sharing one serializer write path (din/start/load) between requesters.
// Define SR_WRITE_ARB_TIMEOUT_EN to add the WAIT timeout counter and the err path.
module sr_write_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 170,
  parameter int TMO_WIDTH  = 9
) (
  input  logic              clk,
  input  logic              rst,
  sr_write_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    WAIT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic [1:0]            grant_id_q, grant_id_d;
  logic                  busy_q, busy_d;
  logic                  sr_start_q, sr_start_d;
  logic [DATA_WIDTH-1:0] sr_din_q, sr_din_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
`ifdef SR_WRITE_ARB_TIMEOUT_EN
  logic [N_REQ-1:0]      err_q, err_d;
  logic [TMO_WIDTH-1:0]  cnt_q, cnt_d;
`endif

  logic [1:0]            win_id;
  logic [DATA_WIDTH-1:0] win_data;

  function automatic logic [N_REQ-1:0] id_onehot(input logic [1:0] id);
    id_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (id == 2'(i)) id_onehot[i] = 1'b1;
    end
  endfunction

  // Search starts one past the last winner, so a requester that keeps req high drops to lowest priority.
  always_comb begin : rr_pick
    int   ptr;
    int   cand;
    logic found;
    win_id = '0;
    found  = 1'b0;
    cand   = 0;
    ptr    = (int'(last_grant_q) + 1) % N_REQ;
    for (int off = 0; off < N_REQ; off++) begin
      cand = (ptr + off) % N_REQ;
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        win_id = 2'(cand);
      end
    end
    win_data = bus.req_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
  end

  // NOTE: every signal driven here gets a default first; a path that skips one would infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
    sr_din_d     = sr_din_q;
    sr_start_d   = 1'b0;
    ack_d        = '0;
`ifdef SR_WRITE_ARB_TIMEOUT_EN
    err_d        = '0;
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_id_d = win_id;
          sr_din_d   = win_data;
          busy_d     = 1'b1;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        sr_start_d = 1'b1;
        state_d    = START;
      end
      START: begin
`ifdef SR_WRITE_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        // A load on the expiry edge wins over the timeout.
        if (bus.sr_load) begin
          ack_d   = id_onehot(grant_id_q);
          state_d = DONE;
        end
`ifdef SR_WRITE_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_d) begin
            err_d   = id_onehot(grant_id_q);
            state_d = DONE;
          end
        end
`endif
      end
      DONE: begin
        last_grant_d = grant_id_q;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 2'(N_REQ - 1);
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      sr_din_q     <= '0;
      sr_start_q   <= 1'b0;
      ack_q        <= '0;
`ifdef SR_WRITE_ARB_TIMEOUT_EN
      err_q        <= '0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      sr_din_q     <= sr_din_d;
      sr_start_q   <= sr_start_d;
      ack_q        <= ack_d;
`ifdef SR_WRITE_ARB_TIMEOUT_EN
      err_q        <= err_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;
  assign bus.sr_din   = sr_din_q;
  assign bus.sr_start = sr_start_q;
  assign bus.ack      = ack_q;
`ifdef SR_WRITE_ARB_TIMEOUT_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = '0;
`endif

endmodule

// File: tb/tb_sr_write_arbiter.sv
// Self-checking bench for sr_write_arbiter: a transaction-level model (age since grant, wait-cycle count)
// is compared every cycle, plus literal timing/ordering expectations per directed scenario.
module tb_sr_write_arbiter;
  localparam int N  = 2;
  localparam int DW = 170;
  localparam int TW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  sr_write_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  sr_write_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TMO_WIDTH(TW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0]    m_last, m_gid;
  logic          m_busy, m_start, m_done;
  logic [N-1:0]  m_ack, m_err;
  logic [DW-1:0] m_din;
  int            m_age, m_waited;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int w;
    if (rst) begin
      m_last = 2'(N - 1); m_gid = '0; m_busy = 1'b0; m_start = 1'b0; m_done = 1'b0;
      m_ack = '0; m_err = '0; m_din = '0; m_age = 0; m_waited = 0;
    end else begin
      m_start = 1'b0; m_ack = '0; m_err = '0;
      if (m_done) begin
        m_done = 1'b0; m_busy = 1'b0; m_last = m_gid;
      end else if (!m_busy) begin
        w = rr_pick(bus.req, int'(m_last));
        if (w >= 0) begin
          m_busy = 1'b1; m_gid = 2'(w); m_din = bus.req_data[w*DW +: DW];
          m_age = 0; m_waited = 0;
        end
      end else begin
        m_age++;
        if (m_age == 1) m_start = 1'b1;
        else if (m_age >= 3) begin
          if (bus.sr_load) begin
            m_ack[m_gid] = 1'b1; m_done = 1'b1;
          end else begin
            m_waited++;
`ifdef SR_WRITE_ARB_TIMEOUT_EN
            if (m_waited == 2**TW - 1) begin
              m_err[m_gid] = 1'b1; m_done = 1'b1;
            end
`endif
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  int start_cnt = 0, start_cyc = 0, ack_cnt = 0, ack_cyc = 0, err_cnt = 0, err_cyc = 0;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("busy", bus.busy, m_busy);
      check("grant_id", bus.grant_id, m_gid);
      check("sr_din", bus.sr_din, m_din);
      check("sr_start", bus.sr_start, m_start);
      check("ack", bus.ack, m_ack);
      check("err", bus.err, m_err);
      if (bus.sr_start) begin start_cnt++; start_cyc = cyc; end
      if (bus.ack != '0) begin ack_cnt++; ack_cyc = cyc; end
      if (bus.err != '0) begin err_cnt++; err_cyc = cyc; end
    end
  end

  // ---------------- serializer model ----------------
  int ser_delay = 60;
  int load_cyc = 0;

  initial begin
    bus.sr_load = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.sr_start === 1'b1 && ser_delay >= 0) begin
        repeat (ser_delay) @(negedge clk);
        bus.sr_load = 1'b1;
        load_cyc = cyc;
        @(negedge clk);
        bus.sr_load = 1'b0;
      end
    end
  end

  task automatic wait_done(input string nm, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if ((bus.ack | bus.err) != '0) ok = 1'b1;
    end
    check({"wait_", nm}, ok, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  logic [DW-1:0] w0, w1;
  int            req_cyc, a_before;
  bit            seen;

  initial begin
    w0 = 170'h3_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_A5;
    w1 = 170'h2_DEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_5A;
    bus.req = '0;
    bus.req_data = {w1, w0};

    #2;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_grant_id", bus.grant_id, 2'd0);
    check("rst_sr_din", bus.sr_din, '0);
    check("rst_sr_start", bus.sr_start, 1'b0);
    check("rst_ack", bus.ack, 2'b00);
    check("rst_err", bus.err, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Simultaneous requests, two rounds: req0 then req1 each time.
    ser_delay = 60;
    for (int round = 0; round < 2; round++) begin
      @(negedge clk);
      bus.req = 2'b11;
      for (int k = 0; k < 2; k++) begin
        wait_done("simul", 200);
        check("simul_gid", bus.grant_id, 2'(k));
        check("simul_ack", bus.ack, 2'b01 << k);
        bus.req[k] = 1'b0;
      end
    end

    // Single write with the long serializer latency.
    ser_delay = 173;
    @(negedge clk);
    start_cnt = 0; ack_cnt = 0;
    bus.req = 2'b01;
    req_cyc = cyc;
    wait_done("single", 400);
    check("single_din", bus.sr_din, w0);
    check("single_ack", bus.ack, 2'b01);
    check("single_start_lat", 32'(start_cyc - req_cyc), 32'd2);
    check("single_start_cnt", 32'(start_cnt), 32'd1);
    check("single_ack_lat", 32'(ack_cyc - load_cyc), 32'd1);
    bus.req = 2'b00;
    @(negedge clk);
    check("single_ack_width", bus.ack, 2'b00);
    check("single_ack_cnt", 32'(ack_cnt), 32'd1);

    // Fairness: req0 held, req1 arrives during req0's WAIT.
    ser_delay = 60;
    bus.req_data = {w0, w1};
    bus.req = 2'b01;
    repeat (20) @(negedge clk);
    bus.req[1] = 1'b1;
    wait_done("fair0", 200);
    check("fair_first", bus.grant_id, 2'd0);
    wait_done("fair1", 200);
    check("fair_second", bus.grant_id, 2'd1);
    check("fair_din", bus.sr_din, w0);
    bus.req[1] = 1'b0;
    wait_done("fair2", 200);
    check("fair_third", bus.grant_id, 2'd0);
    bus.req = 2'b00;
    @(negedge clk);

`ifdef SR_WRITE_ARB_TIMEOUT_EN
    // Timeout: no load ever comes back.
    ser_delay = -1;
    ack_cnt = 0;
    bus.req = 2'b10;
    wait_done("tmo", 700);
    check("tmo_err", bus.err, 2'b10);
    check("tmo_ack", bus.ack, 2'b00);
    check("tmo_lat", 32'(err_cyc - start_cyc), 32'd512);
    bus.req = 2'b00;
    @(negedge clk);
    check("tmo_busy_fall", bus.busy, 1'b0);
    ser_delay = 60;
    bus.req = 2'b01;
    wait_done("tmo_next", 200);
    check("tmo_next_ack", bus.ack, 2'b01);
    bus.req = 2'b00;
`else
    // No timeout: WAIT holds until the load finally arrives.
    ser_delay = -1;
    ack_cnt = 0;
    bus.req = 2'b10;
    repeat (2000) @(negedge clk);
    check("hold_busy", bus.busy, 1'b1);
    check("hold_no_ack", 32'(ack_cnt), 32'd0);
    bus.sr_load = 1'b1;
    @(negedge clk);
    bus.sr_load = 1'b0;
    check("hold_ack", bus.ack, 2'b10);
    bus.req = 2'b00;
    ser_delay = 60;
`endif

    // Spurious load while idle.
    repeat (3) @(negedge clk);
    a_before = ack_cnt;
    bus.sr_load = 1'b1;
    @(negedge clk);
    bus.sr_load = 1'b0;
    repeat (4) @(negedge clk);
    check("spurious_no_ack", 32'(ack_cnt), 32'(a_before));
    check("spurious_idle", bus.busy, 1'b0);

    // Reset 50 cycles into WAIT.
    ser_delay = -1;
    bus.req = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.sr_start === 1'b1) seen = 1'b1;
    end
    check("rst_start_seen", seen, 1'b1);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_grant_id", bus.grant_id, 2'd0);
    check("arst_sr_din", bus.sr_din, '0);
    check("arst_sr_start", bus.sr_start, 1'b0);
    check("arst_ack", bus.ack, 2'b00);
    check("arst_err", bus.err, 2'b00);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ser_delay = 60;
    @(negedge clk);
    bus.req = 2'b11;
    @(posedge clk);
    #2;
    check("post_rst_busy", bus.busy, 1'b1);
    check("post_rst_gid", bus.grant_id, 2'd0);
    for (int k = 0; k < 2; k++) begin
      wait_done("post_rst", 200);
      check("post_rst_order", bus.grant_id, 2'(k));
      bus.req[k] = 1'b0;
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
